// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : timer_pkg
//  Description : Shared state encoding and default sizing for the
//                multi-mode countdown timer.
//  Revision    : 1.0 - initial release
// ============================================================================
package timer_pkg;

    // Timer FSM states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    localparam int unsigned c_default_width           = 4;
    localparam int unsigned c_default_cycles_per_tick = 100_000_000;

endpackage : timer_pkg
`default_nettype wire

// File: rtl/tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tick_gen
//  Description : Prescaler producing a 1-cycle tick every CYCLES_PER_TICK
//                clocks plus a half-rate enable on every second tick.
//  Revision    : 1.0 - initial release
// ============================================================================
module tick_gen
    import timer_pkg::*;
#(
    parameter int unsigned CYCLES_PER_TICK = c_default_cycles_per_tick
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic hold,
    output logic one_hz_enable,
    output logic half_hz_enable
);

    localparam int unsigned c_presc_w = (CYCLES_PER_TICK > 1) ? $clog2(CYCLES_PER_TICK) : 1;
    localparam logic [c_presc_w-1:0] c_last = c_presc_w'(CYCLES_PER_TICK - 1);
    localparam logic [c_presc_w-1:0] c_one  = c_presc_w'(1);

    logic [c_presc_w-1:0] r_presc;
    logic                 r_half_phase;
    logic                 w_wrap;

    assign w_wrap         = (r_presc == c_last);
    // A held prescaler must not emit a tick even when parked on the last count
    assign one_hz_enable  = w_wrap & ~hold;
    assign half_hz_enable = one_hz_enable & r_half_phase;

    // Prescaler counter and half-rate phase; clear restarts the tick period
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_presc      <= '0;
            r_half_phase <= 1'b0;
        end else if (clear) begin
            r_presc      <= '0;
            r_half_phase <= 1'b0;
        end else if (!hold) begin
            if (w_wrap) begin
                r_presc      <= '0;
                r_half_phase <= ~r_half_phase;
            end else begin
                r_presc <= r_presc + c_one;
            end
        end
    end

endmodule : tick_gen
`default_nettype wire

// File: rtl/multi_mode_timer.sv
`default_nettype none
// ============================================================================
//  Module      : multi_mode_timer
//  Description : WIDTH-bit countdown timer with one-shot / auto-reload modes,
//                pause, expiry flag, terminal-count pulse and exported
//                prescaled enables.
//  Revision    : 1.0 - initial release
// ============================================================================
module multi_mode_timer
    import timer_pkg::*;
#(
    parameter int unsigned WIDTH           = c_default_width,
    parameter int unsigned CYCLES_PER_TICK = c_default_cycles_per_tick
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] value,
    input  logic             start_timer,
    input  logic             auto_reload,
    input  logic             pause,
    output logic [WIDTH-1:0] count,
    output logic             running,
    output logic             expired,
    output logic             done_pulse,
    output logic             one_hz_enable,
    output logic             half_hz_enable
);

    localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

    state_t           r_state;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_load;
    logic             r_mode;
    logic             r_done;
    logic             r_running;
    logic             r_expired;
    logic             w_hold;
    logic             w_tick;

    // Pause only freezes the prescaler while a countdown is active
    assign w_hold = pause & ((r_state == ST_RUN) | (r_state == ST_PAUSED));

    tick_gen #(
        .CYCLES_PER_TICK (CYCLES_PER_TICK)
    ) u_tick_gen (
        .clock          (clock),
        .reset          (reset),
        .clear          (start_timer),
        .hold           (w_hold),
        .one_hz_enable  (w_tick),
        .half_hz_enable (half_hz_enable)
    );

    assign one_hz_enable = w_tick;
    assign count         = r_count;
    assign running       = r_running;
    assign expired       = r_expired;
    assign done_pulse    = r_done;

    // Timer FSM with registered count, mode and status outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_count   <= '0;
            r_load    <= '0;
            r_mode    <= 1'b0;
            r_done    <= 1'b0;
            r_running <= 1'b0;
            r_expired <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start_timer) begin
                // Restart wins over everything, including a coincident tick
                r_load  <= value;
                r_mode  <= auto_reload;
                r_count <= value;
                if (value == '0) begin
                    r_state   <= ST_EXPIRED;
                    r_running <= 1'b0;
                    r_expired <= 1'b1;
                    r_done    <= 1'b1;
                end else begin
                    r_state   <= ST_RUN;
                    r_running <= 1'b1;
                    r_expired <= 1'b0;
                end
            end else begin
                case (r_state)
                    ST_RUN, ST_PAUSED: begin
                        if (pause) begin
                            r_state <= ST_PAUSED;
                        end else begin
                            // A tick on the resume cycle is honoured, not lost
                            r_state <= ST_RUN;
                            if (w_tick) begin
                                if (r_count > c_one) begin
                                    r_count <= r_count - c_one;
                                end else begin
                                    r_done <= 1'b1;
                                    if (r_mode) begin
                                        r_count <= r_load;
                                    end else begin
                                        r_count   <= '0;
                                        r_state   <= ST_EXPIRED;
                                        r_running <= 1'b0;
                                        r_expired <= 1'b1;
                                    end
                                end
                            end
                        end
                    end
                    default: begin
                        // IDLE and EXPIRED hold until the next start
                    end
                endcase
            end
        end
    end

endmodule : multi_mode_timer
`default_nettype wire
